fpcvt_arbiter: RTL and testbench
================================

Name: fpcvt_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 13-bit two's-complement to 9-bit floating-point converter datapath (S/E/F output: 1-bit sign, 3-bit exponent, 5-bit significand).
- Accepts samples over valid/ready from two independent sources.
- Drives a single external converter instance from a registered operand.
- Captures its S/E/F result and presents it downstream with a source tag over valid/ready.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with req0 highest.
- OPW, 13, operand width. Fixed at 13 to match the converter; any other value is unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- req0_valid  input  1  source 0 has an operand
- req0_data  input  13  source 0 operand, two's complement
- req0_ready  output  1  source 0 operand accepted this cycle
- req1_valid  input  1  source 1 has an operand
- req1_data  input  13  source 1 operand, two's complement
- req1_ready  output  1  source 1 operand accepted this cycle
- cvt_d  output  13  registered operand to the converter
- cvt_s  input  1  converter sign, combinational from cvt_d
- cvt_e  input  3  converter exponent
- cvt_f  input  5  converter significand
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_s  output  1  result sign
- out_e  output  3  result exponent
- out_f  output  5  result significand
- out_src  output  1  requester id of the result

Behaviour:
- Clock and reset: one clock domain. rst_n is sampled only on the rising edge of clk (synchronous, active-low).
- Reset values: state=IDLE; out_valid=0; out_s=0; out_e=0; out_f=0; out_src=0; cvt_d=0; last_src=1, so req0 wins the first tie.
- States:
  - IDLE: grant logic is active.
  - CONV: the operand is held on cvt_d.
  - OUT: the result is held until downstream accepts it.
- Grant (combinational in IDLE only):
  - Only req0_valid set → grant 0. Only req1_valid set → grant 1.
  - Both set, ARB_MODE=0 → grant the source opposite last_src.
  - Both set, ARB_MODE=1 → grant 0.
- Ready:
  - reqN_ready = (state==IDLE) & reqN_valid & grant==N.
  - At most one ready is high per cycle. Both readys are 0 in CONV and OUT.
- Transfer: on reqN_valid & reqN_ready:
  - cvt_d <= reqN_data; src_q <= N; last_src <= N; state -> CONV.
- CONV (exactly 1 cycle):
  - out_s/out_e/out_f <= cvt_s/cvt_e/cvt_f; out_src <= src_q; out_valid <= 1; state -> OUT.
- OUT:
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On out_ready=1: out_valid <= 0, state -> IDLE. out_s/e/f/src keep their last values.
- Latency and throughput:
  - Accept at edge N → out_valid high from edge N+2.
  - Maximum throughput is one result per 3 cycles with out_ready tied high.
- cvt_d holds its last operand outside CONV; the converter may glitch freely because its result is sampled only in CONV.
- Requester data is not latched except on the accepting edge. A source may drop valid without penalty while not granted.
- Starvation: in round-robin mode, with both sources continuously valid, grants alternate 0,1,0,1. No source waits more than one result.
- Reset mid-operation: rst_n low in any state drops the in-flight sample silently and restores reset values on that edge. No ready is asserted during the reset cycle.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro FPCVT_ARB_CNT_EN.
- When defined, adds outputs cnt0 and cnt1 (8 bits each): saturating counts of completed results per source.
  - Increment on out_valid & out_ready for out_src.
  - Saturate at 255.
  - Cleared by rst_n.
- When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Test Plan:
- Single request, out_ready=1: req0_data=13'd422 → req0_ready at accept edge N; out_valid at N+2 with out_s=0, out_e=3'b100, out_f=5'b11010, out_src=0.
- Boundary operand: req1_data=13'h1000 (-4096) → out_s=1, out_e=3'b111, out_f=5'b11111, out_src=1.
- Both sources valid continuously, ARB_MODE=0, req0=56, req1=-56 → out_src sequence 0,1,0,1; out_e=3'b001, out_f=5'b11100; out_s alternates 0/1.
- ARB_MODE=1, both valid for 4 results → out_src 0,0,0,0; req1_ready never asserted.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, both readys 0; release → out_valid drops next edge, next grant the following cycle.
- Reset in CONV: rst_n=0 one cycle → out_valid=0, state IDLE, no result emitted. Next tie grants req0. With FPCVT_ARB_CNT_EN defined, cnt0 and cnt1 read 0.

Source files
------------

// File: rtl/fpcvt_arbiter.sv
`default_nettype none
// fpcvt_arbiter: two-source arbiter/sequencer feeding one shared 13b -> S/E/F converter.
// Optional macro FPCVT_ARB_CNT_EN adds saturating per-source result counters cnt0/cnt1.
module fpcvt_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int OPW      = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_data,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_data,
  output logic           req1_ready,
  output logic [OPW-1:0] cvt_d,
  input  logic           cvt_s,
  input  logic [2:0]     cvt_e,
  input  logic [4:0]     cvt_f,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_s,
  output logic [2:0]     out_e,
  output logic [4:0]     out_f,
  output logic           out_src
`ifdef FPCVT_ARB_CNT_EN
  ,
  output logic [7:0]     cnt0,
  output logic [7:0]     cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic             last_src_q;
  logic             src_q;
  logic [OPW-1:0]   cvt_d_q;
  logic             out_valid_q;
  logic             out_s_q;
  logic [2:0]       out_e_q;
  logic [4:0]       out_f_q;
  logic             out_src_q;

  logic             grant_d;
  logic             accept_d;
  logic [OPW-1:0]   grant_data_d;

  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = (ARB_MODE == 1) ? 1'b0 : ~last_src_q;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  // Readys are gated by rst_n so nothing is handed over on a reset edge.
  assign req0_ready   = rst_n & (state_q == S_IDLE) & req0_valid & ~grant_d;
  assign req1_ready   = rst_n & (state_q == S_IDLE) & req1_valid &  grant_d;
  assign accept_d     = req0_ready | req1_ready;
  assign grant_data_d = grant_d ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_src_q  <= 1'b1;
      src_q       <= 1'b0;
      cvt_d_q     <= '0;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= 3'd0;
      out_f_q     <= 5'd0;
      out_src_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            cvt_d_q    <= grant_data_d;
            src_q      <= grant_d;
            last_src_q <= grant_d;
            state_q    <= S_CONV;
          end
        end
        S_CONV: begin
          out_s_q     <= cvt_s;
          out_e_q     <= cvt_e;
          out_f_q     <= cvt_f;
          out_src_q   <= src_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cvt_d     = cvt_d_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_e     = out_e_q;
  assign out_f     = out_f_q;
  assign out_src   = out_src_q;

`ifdef FPCVT_ARB_CNT_EN
  logic [7:0] cnt0_q;
  logic [7:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (out_valid_q && out_ready) begin
      if (!out_src_q && (cnt0_q != 8'hFF)) cnt0_q <= cnt0_q + 8'd1;
      if ( out_src_q && (cnt1_q != 8'hFF)) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_arbiter.sv
`default_nettype none
// tb_fpcvt_arbiter: directed and randomized checks of a round-robin and a fixed-priority instance
// against a transaction-level reference model and a behavioural converter.
module tb_fpcvt_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, ordy = 1'b0;
  logic [12:0] d0 = '0, d1 = '0;

  logic        r0 [2];
  logic        r1 [2];
  logic [12:0] cvtd [2];
  logic        cs [2];
  logic [2:0]  ce [2];
  logic [4:0]  cf [2];
  logic        ov [2];
  logic        os [2];
  logic [2:0]  oe [2];
  logic [4:0]  ofr [2];
  logic        osrc [2];
`ifdef FPCVT_ARB_CNT_EN
  logic [7:0]  c0 [2];
  logic [7:0]  c1 [2];
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Converter: sign-magnitude, significand = top 5 bits of |x| (truncated), exponent = right shift.
  function automatic logic [8:0] conv(input logic [12:0] x);
    int v, mag, e;
    v   = $signed(x);
    mag = (v < 0) ? -v : v;
    e   = 0;
    while ((mag >> e) > 31) e++;
    if (e > 7) return {1'b1, 3'd7, 5'd31};
    return {(v < 0), e[2:0], 5'(mag >> e)};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign {cs[gi], ce[gi], cf[gi]} = conv(cvtd[gi]);
    fpcvt_arbiter #(.ARB_MODE(gi), .OPW(13)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (v0),
      .req0_data  (d0),
      .req0_ready (r0[gi]),
      .req1_valid (v1),
      .req1_data  (d1),
      .req1_ready (r1[gi]),
      .cvt_d      (cvtd[gi]),
      .cvt_s      (cs[gi]),
      .cvt_e      (ce[gi]),
      .cvt_f      (cf[gi]),
      .out_valid  (ov[gi]),
      .out_ready  (ordy),
      .out_s      (os[gi]),
      .out_e      (oe[gi]),
      .out_f      (ofr[gi]),
      .out_src    (osrc[gi])
`ifdef FPCVT_ARB_CNT_EN
      ,
      .cnt0       (c0[gi]),
      .cnt1       (c1[gi])
`endif
    );
  end

  // Reference model: one outstanding transaction per instance, tracked by cycle number.
  int          cyc = 0;
  logic        pend_m [2]  = '{1'b0, 1'b0};
  logic        last_m [2]  = '{1'b1, 1'b1};
  int          acc_m  [2]  = '{0, 0};
  logic        xsrc_m [2]  = '{1'b0, 1'b0};
  logic [8:0]  xres_m [2]  = '{9'd0, 9'd0};
  logic [9:0]  hold_m [2]  = '{10'd0, 10'd0};
  logic [12:0] xcvt_m [2]  = '{13'd0, 13'd0};
  int          cntm [2][2] = '{'{0, 0}, '{0, 0}};
  logic        win, e0, e1, eov;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (v0 && v1) win = (m == 1) ? 1'b0 : ~last_m[m];
      else          win = v1;
      e0  = rst_n && !pend_m[m] && v0 && !win;
      e1  = rst_n && !pend_m[m] && v1 &&  win;
      eov = pend_m[m] && (cyc >= acc_m[m] + 2);
      chk($sformatf("m%0d req0_ready", m), r0[m], e0);
      chk($sformatf("m%0d req1_ready", m), r1[m], e1);
      chk($sformatf("m%0d out_valid", m), ov[m], eov);
      chk($sformatf("m%0d out{src,s,e,f}", m), {osrc[m], os[m], oe[m], ofr[m]}, hold_m[m]);
      chk($sformatf("m%0d cvt_d", m), cvtd[m], xcvt_m[m]);
`ifdef FPCVT_ARB_CNT_EN
      chk($sformatf("m%0d cnt0", m), c0[m], cntm[m][0]);
      chk($sformatf("m%0d cnt1", m), c1[m], cntm[m][1]);
`endif
      if (!rst_n) begin
        pend_m[m] = 1'b0;
        last_m[m] = 1'b1;
        hold_m[m] = '0;
        xcvt_m[m] = '0;
        cntm[m][0] = 0;
        cntm[m][1] = 0;
      end else begin
        if (pend_m[m] && (cyc == acc_m[m] + 1)) hold_m[m] = {xsrc_m[m], xres_m[m]};
        if (eov && ordy) begin
          pend_m[m] = 1'b0;
          if (cntm[m][xsrc_m[m]] < 255) cntm[m][xsrc_m[m]]++;
        end else if (e0 || e1) begin
          pend_m[m] = 1'b1;
          acc_m[m]  = cyc;
          xsrc_m[m] = win;
          xcvt_m[m] = win ? d1 : d0;
          xres_m[m] = conv(win ? d1 : d0);
          last_m[m] = win;
        end
      end
    end
    cyc++;
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit src, input logic [12:0] d);
    bit got = 1'b0;
    cyc1();
    if (src) begin v1 = 1'b1; d1 = d; end
    else     begin v0 = 1'b1; d0 = d; end
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = src ? r1[0] : r0[0];
    end
    chk("send ready", got, 1);
    cyc1();
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = ov[0];
    end
    chk(tag, seen, 1);
  endtask

  logic [12:0] corner [8] = '{13'd0, 13'd1, 13'h1FFF, 13'h1000, 13'h0FFF, 13'd31, 13'd32, 13'h1FE0};
  logic [3:0]  seqv [2];
  int          nres [2];
  bit          saw_r1fp;
  logic [9:0]  snap;

  initial begin
    rst_n = 1'b0;
    ordy  = 1'b1;
    cyc1();
    cyc1();
    rst_n = 1'b1;

    // Single request from source 0
    send(0, 13'd422);
    wait_out("t1 out_valid");
    for (int m = 0; m < 2; m++)
      chk("t1 422 {src,s,e,f}", {osrc[m], os[m], oe[m], ofr[m]}, {1'b0, 1'b0, 3'b100, 5'b11010});

    // Most negative operand from source 1
    send(1, 13'h1000);
    wait_out("t2 out_valid");
    for (int m = 0; m < 2; m++)
      chk("t2 -4096 {src,s,e,f}", {osrc[m], os[m], oe[m], ofr[m]}, {1'b1, 1'b1, 3'b111, 5'b11111});

    // Both sources continuously valid
    cyc1();
    v0 = 1'b1; d0 = 13'd56;
    v1 = 1'b1; d1 = 13'h1FC8;
    seqv = '{4'd0, 4'd0};
    nres = '{0, 0};
    saw_r1fp = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (r1[1]) saw_r1fp = 1'b1;
      for (int m = 0; m < 2; m++) begin
        if (ov[m] && ordy && nres[m] < 4) begin
          seqv[m] = {seqv[m][2:0], osrc[m]};
          chk("tie {e,f}", {oe[m], ofr[m]}, {3'b001, 5'b11100});
          chk("tie sign", os[m], (m == 0) ? 1'((nres[m] % 2) == 1) : 1'b0);
          nres[m]++;
        end
      end
    end
    chk("rr result count", nres[0], 4);
    chk("rr src sequence", seqv[0], 4'b0101);
    chk("fp result count", nres[1], 4);
    chk("fp src sequence", seqv[1], 4'b0000);
    chk("fp req1_ready seen", saw_r1fp, 0);
    cyc1();
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (4) cyc1();

    // Backpressure
    ordy = 1'b0;
    send(0, 13'h0ABC);
    wait_out("bp out_valid");
    snap = {osrc[0], os[0], oe[0], ofr[0]};
    cyc1();
    v0 = 1'b1;
    v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp hold valid", ov[0], 1);
      chk("bp hold data", {osrc[0], os[0], oe[0], ofr[0]}, snap);
      chk("bp readys", {r0[0], r1[0]}, 2'b00);
    end
    cyc1();
    ordy = 1'b1;
    @(negedge clk);
    chk("bp still valid", ov[0], 1);
    @(negedge clk);
    chk("bp valid drop", ov[0], 0);
    chk("bp regrant rr", r1[0], 1);
    cyc1();
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (4) cyc1();

    // Reset while in CONV
    send(0, 13'd100);
    rst_n = 1'b0;
    cyc1();
    rst_n = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    @(negedge clk);
    chk("rst out_valid", ov[0], 0);
    chk("rst tie rr", {r0[0], r1[0]}, 2'b10);
    chk("rst tie fp", {r0[1], r1[1]}, 2'b10);
`ifdef FPCVT_ARB_CNT_EN
    chk("rst cnt0", c0[0], 0);
    chk("rst cnt1", c1[0], 0);
`endif
    cyc1();
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (4) cyc1();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      v0    = ($urandom_range(0, 3) != 0);
      v1    = ($urandom_range(0, 3) != 0);
      d0    = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 7)] : 13'($urandom);
      d1    = ($urandom_range(0, 4) == 0) ? corner[$urandom_range(0, 7)] : 13'($urandom);
      ordy  = ($urandom_range(0, 2) != 0);
      cyc1();
    end
    rst_n = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) cyc1();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
